// File: rtl/escalonador_pkg.sv
// Shared definitions for the round-robin process scheduler.
//   estado_t : scheduler FSM states (OS, LOAD, RUN)
//   ID_*     : process identifiers driven on id_proc
//   outro()  : the other user process id (01 <-> 10)
package escalonador_pkg;

  typedef enum logic [1:0] {
    ST_OS   = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } estado_t;

  localparam logic [1:0] ID_OS = 2'b00;
  localparam logic [1:0] ID_P1 = 2'b01;
  localparam logic [1:0] ID_P2 = 2'b10;

  function automatic logic [1:0] outro(input logic [1:0] id);
    return (id == ID_P1) ? ID_P2 : ID_P1;
  endfunction

endpackage

// File: rtl/escalonador_proc_contador.sv
// Quantum down-counter for the scheduler.
//   clock, reset : rising-edge clock, synchronous active-high reset (count -> 0)
//   reload       : count <= QUANTUM-1 (wins over enable)
//   enable       : count <= count-1
//   zero         : count == 0, i.e. the last cycle of the current slice
module contador_quantum #(
  parameter int QUANTUM = 100
) (
  input  logic clock,
  input  logic reset,
  input  logic reload,
  input  logic enable,
  output logic zero
);

  localparam int CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam logic [CW-1:0] RELOAD_VAL = CW'(QUANTUM - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset)       cnt <= '0;
    else if (reload) cnt <= RELOAD_VAL;
    else if (enable) cnt <= cnt - CW'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/escalonador_proc.sv
// Round-robin scheduler for two user processes plus the OS (id 00).
// Time-slices with a quantum counter, saves/restores each process PC on a
// switch and hands control back to the OS once both user processes finish.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   inicia       : OS asks to start user scheduling (only looked at in OS)
//   fim_proc     : running user process committed its halt (only looked at in RUN)
//   pc_prox      : PC fetch will use next cycle; saved on a time-slice switch
//   id_proc      : running process id (00 OS, 01 proc 1, 10 proc 2)
//   pc_carga     : PC to load into fetch; valid while carrega_pc = 1
//   carrega_pc   : 1-cycle pulse, fetch PC <= pc_carga
//   troca        : switch cycle, core stalls
//   concluido    : 1-cycle pulse, both user processes have finished
//   estado       : current FSM state, for observation
// The control outputs are simple pulses/levels; there is no valid/ready
// handshake, the core is expected to honour carrega_pc/troca in the same cycle.
module escalonador_proc
  import escalonador_pkg::*;
#(
  parameter int QUANTUM = 100,
  parameter int ADDR_W  = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inicia,
  input  logic              fim_proc,
  input  logic [ADDR_W-1:0] pc_prox,
  output logic [1:0]        id_proc,
  output logic [ADDR_W-1:0] pc_carga,
  output logic              carrega_pc,
  output logic              troca,
  output logic              concluido,
  output estado_t           estado
);

  estado_t state, state_n;
  logic [1:0] tgt, tgt_n;
  logic [1:0] cur, cur_n;
  logic [2:1] vivo, vivo_n;
  logic [ADDR_W-1:0] pc_os, pc_p1, pc_p2;

  logic save_en;
  logic [1:0] save_id;
  logic [1:0] other;
  logic other_vivo;
  logic reload, enable, zero;

  logic [1:0]        id_n;
  logic [ADDR_W-1:0] pc_carga_n;
  logic              conc_n;

  contador_quantum #(.QUANTUM(QUANTUM)) u_contador (
    .clock  (clock),
    .reset  (reset),
    .reload (reload),
    .enable (enable),
    .zero   (zero)
  );

  always_comb begin
    state_n    = state;
    tgt_n      = tgt;
    cur_n      = cur;
    vivo_n     = vivo;
    save_en    = 1'b0;
    save_id    = ID_OS;
    conc_n     = 1'b0;
    reload     = 1'b0;
    enable     = 1'b0;
    other      = outro(cur);
    other_vivo = (other == ID_P1) ? vivo[1] : vivo[2];

    case (state)
      ST_OS: begin
        if (inicia) begin
          save_en = 1'b1;
          save_id = ID_OS;
          vivo_n  = 2'b11;
          // Both processes are revived here, so the lowest live one is proc 1.
          tgt_n   = ID_P1;
          state_n = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cur_n   = tgt;
        reload  = 1'b1;
        state_n = (tgt == ID_OS) ? ST_OS : ST_RUN;
      end
      ST_RUN: begin
        // Reload at zero so the counter never wraps, even when leaving RUN.
        if (zero) reload = 1'b1;
        else      enable = 1'b1;
        if (fim_proc) begin
          if (cur == ID_P1) vivo_n[1] = 1'b0;
          else              vivo_n[2] = 1'b0;
          if (other_vivo) begin
            tgt_n = other;
          end else begin
            tgt_n  = ID_OS;
            conc_n = 1'b1;
          end
          state_n = ST_LOAD;
        end else if (zero && other_vivo) begin
          save_en = 1'b1;
          save_id = cur;
          tgt_n   = other;
          state_n = ST_LOAD;
        end
      end
      default: state_n = ST_OS;
    endcase

    // Outputs describe the state being entered; they are registered below.
    case (state_n)
      ST_LOAD: id_n = tgt_n;
      ST_RUN:  id_n = cur_n;
      default: id_n = ID_OS;
    endcase

    pc_carga_n = pc_carga;
    if (state_n == ST_LOAD) begin
      case (tgt_n)
        ID_P1:   pc_carga_n = pc_p1;
        ID_P2:   pc_carga_n = pc_p2;
        default: pc_carga_n = pc_os;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_OS;
      tgt        <= ID_OS;
      cur        <= ID_P1;
      vivo       <= 2'b11;
      pc_os      <= '0;
      pc_p1      <= '0;
      pc_p2      <= '0;
      id_proc    <= ID_OS;
      pc_carga   <= '0;
      carrega_pc <= 1'b0;
      troca      <= 1'b0;
      concluido  <= 1'b0;
    end else begin
      state      <= state_n;
      tgt        <= tgt_n;
      cur        <= cur_n;
      vivo       <= vivo_n;
      id_proc    <= id_n;
      pc_carga   <= pc_carga_n;
      carrega_pc <= (state_n == ST_LOAD);
      troca      <= (state_n == ST_LOAD);
      concluido  <= conc_n;
      if (save_en) begin
        case (save_id)
          ID_P1:   pc_p1 <= pc_prox;
          ID_P2:   pc_p2 <= pc_prox;
          default: pc_os <= pc_prox;
        endcase
      end
    end
  end

  assign estado = state;

endmodule

// File: tb/tb_escalonador_proc.sv
module tb_escalonador_proc;
  import escalonador_pkg::*;

  localparam int QUANTUM = 4;
  localparam int ADDR_W  = 9;

  logic              clk = 1'b0;
  logic              reset;
  logic              inicia;
  logic              fim_proc;
  logic [ADDR_W-1:0] pc_prox;
  logic [1:0]        id_proc;
  logic [ADDR_W-1:0] pc_carga;
  logic              carrega_pc;
  logic              troca;
  logic              concluido;
  estado_t           estado;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  escalonador_proc #(.QUANTUM(QUANTUM), .ADDR_W(ADDR_W)) dut (
    .clock      (clk),
    .reset      (reset),
    .inicia     (inicia),
    .fim_proc   (fim_proc),
    .pc_prox    (pc_prox),
    .id_proc    (id_proc),
    .pc_carga   (pc_carga),
    .carrega_pc (carrega_pc),
    .troca      (troca),
    .concluido  (concluido),
    .estado     (estado)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // Mode 0 = OS, 1 = switching, 2 = user process running.
  // m_used counts cycles already executed in the current time slice.
  bit m_valid = 1'b0;
  int m_mode, m_id, m_pc_carga, m_cur, m_tgt, m_used, m_other;
  bit m_carrega, m_troca, m_concl;
  int m_saved [3];
  bit m_alive [3];

  task automatic enter_load(input int t);
    m_mode     = 1;
    m_tgt      = t;
    m_id       = t;
    m_pc_carga = m_saved[t];
    m_carrega  = 1'b1;
    m_troca    = 1'b1;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1;
      m_mode = 0; m_id = 0; m_pc_carga = 0; m_cur = 1; m_tgt = 0; m_used = 0;
      m_carrega = 0; m_troca = 0; m_concl = 0;
      for (int i = 0; i < 3; i++) begin m_saved[i] = 0; m_alive[i] = 1'b1; end
    end else if (m_valid) begin
      m_carrega = 0; m_troca = 0; m_concl = 0;
      case (m_mode)
        0: if (inicia) begin
             m_saved[0] = int'(pc_prox);
             m_alive[1] = 1'b1; m_alive[2] = 1'b1;
             enter_load(1);
           end
        1: begin
             m_cur = m_tgt;
             if (m_tgt == 0) begin m_mode = 0; m_id = 0; end
             else begin m_mode = 2; m_used = 0; m_id = m_cur; end
           end
        default: begin
             m_used++;
             m_other = 3 - m_cur;
             if (fim_proc) begin
               m_alive[m_cur] = 1'b0;
               if (m_alive[m_other]) enter_load(m_other);
               else begin m_concl = 1'b1; enter_load(0); end
             end else if (m_used == QUANTUM) begin
               if (m_alive[m_other]) begin
                 m_saved[m_cur] = int'(pc_prox);
                 enter_load(m_other);
               end else begin
                 m_used = 0;
               end
             end
           end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_id", 32'(id_proc), 32'(m_id));
      chk("cyc_carrega", 32'(carrega_pc), 32'(m_carrega));
      chk("cyc_troca", 32'(troca), 32'(m_troca));
      chk("cyc_concluido", 32'(concluido), 32'(m_concl));
      if (m_carrega) chk("cyc_pc_carga", 32'(pc_carga), 32'(m_pc_carga));
    end
  end

  // Runs the 4 slice cycles of a process, then checks the switch cycle.
  task automatic slice_then_switch(input string nm, input int run_id,
                                   input int nxt_id, input int nxt_pc);
    for (int i = 0; i < QUANTUM; i++) begin
      tick(1);
      chk({nm, "_run_id"}, 32'(id_proc), 32'(run_id));
      chk({nm, "_run_carrega"}, 32'(carrega_pc), 32'd0);
    end
    tick(1);
    chk({nm, "_sw_id"}, 32'(id_proc), 32'(nxt_id));
    chk({nm, "_sw_pc"}, 32'(pc_carga), 32'(nxt_pc));
    chk({nm, "_sw_carrega"}, 32'(carrega_pc), 32'd1);
    chk({nm, "_sw_troca"}, 32'(troca), 32'd1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; inicia = 1'b0; fim_proc = 1'b0; pc_prox = '0;
    tick(2);
    chk("rst_id", 32'(id_proc), 32'd0);
    chk("rst_carrega", 32'(carrega_pc), 32'd0);
    chk("rst_troca", 32'(troca), 32'd0);
    chk("rst_concluido", 32'(concluido), 32'd0);
    reset = 1'b0;

    // start: OS saves 0x050, first LOAD targets proc 1 from 0
    pc_prox = 9'h050; inicia = 1'b1;
    tick(1);
    inicia = 1'b0;
    chk("start_id", 32'(id_proc), 32'd1);
    chk("start_pc", 32'(pc_carga), 32'h000);
    chk("start_carrega", 32'(carrega_pc), 32'd1);
    chk("start_troca", 32'(troca), 32'd1);

    pc_prox = 9'h013; slice_then_switch("p1a", 1, 2, 9'h000);
    pc_prox = 9'h022; slice_then_switch("p2a", 2, 1, 9'h013);
    pc_prox = 9'h031; slice_then_switch("p1b", 1, 2, 9'h022);
    pc_prox = 9'h044; slice_then_switch("p2b", 2, 1, 9'h031);

    // proc 1 halts on its last slice cycle: no save, straight to proc 2
    pc_prox = 9'h0AA;
    tick(QUANTUM);
    fim_proc = 1'b1;
    tick(1);
    fim_proc = 1'b0;
    chk("fim1_id", 32'(id_proc), 32'd2);
    chk("fim1_pc", 32'(pc_carga), 32'h044);
    chk("fim1_carrega", 32'(carrega_pc), 32'd1);

    // proc 2 alone: slices renew without any switch
    for (int i = 0; i < 14; i++) begin
      pc_prox = ADDR_W'($urandom_range(0, 511));
      tick(1);
      chk("solo_id", 32'(id_proc), 32'd2);
      chk("solo_carrega", 32'(carrega_pc), 32'd0);
      chk("solo_troca", 32'(troca), 32'd0);
    end

    // proc 2 halts last: back to OS at 0x050
    fim_proc = 1'b1;
    tick(1);
    fim_proc = 1'b0;
    chk("done_concluido", 32'(concluido), 32'd1);
    chk("done_id", 32'(id_proc), 32'd0);
    chk("done_pc", 32'(pc_carga), 32'h050);
    chk("done_carrega", 32'(carrega_pc), 32'd1);
    tick(1);
    chk("os_id", 32'(id_proc), 32'd0);
    chk("os_concluido", 32'(concluido), 32'd0);
    chk("os_carrega", 32'(carrega_pc), 32'd0);
    tick(2);
    chk("os_idle_id", 32'(id_proc), 32'd0);

    // restart resumes proc 1 from its last saved PC
    pc_prox = 9'h060; inicia = 1'b1;
    tick(1);
    chk("restart_id", 32'(id_proc), 32'd1);
    chk("restart_pc", 32'(pc_carga), 32'h031);

    // inicia held during RUN is ignored; proc 2 is alive again
    slice_then_switch("ign", 1, 2, 9'h044);
    inicia = 1'b0;

    // reset during the switch cycle
    reset = 1'b1;
    tick(1);
    chk("rstload_carrega", 32'(carrega_pc), 32'd0);
    chk("rstload_id", 32'(id_proc), 32'd0);
    chk("rstload_troca", 32'(troca), 32'd0);
    tick(1);
    reset = 1'b0;
    chk("rstload2_id", 32'(id_proc), 32'd0);

    // saved PCs were cleared by reset
    pc_prox = 9'h070; inicia = 1'b1;
    tick(1);
    inicia = 1'b0;
    chk("post_rst_id", 32'(id_proc), 32'd1);
    chk("post_rst_pc", 32'(pc_carga), 32'h000);
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
